// File: rtl/addsub_arbiter.sv
// Round-robin arbiter sharing one N-bit add/subtract datapath among four
// requesters; each granted operation returns sum, carry and overflow.
module addsub_arbiter #(
  parameter int N = 8
) (
  input  logic           Clock,
  input  logic           Resetn,
  input  logic [3:0]     Req,
  input  logic [4*N-1:0] X_all,
  input  logic [4*N-1:0] Y_all,
  input  logic [3:0]     Sub,
  output logic [3:0]     Grant,
  output logic           Busy,
  output logic           Done,
  output logic [1:0]     Id,
  output logic [N-1:0]   S,
  output logic           Cout,
  output logic           Overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e         state_q;
  logic [1:0]     ptr_q;
  logic [1:0]     w_q;
  logic [N-1:0]   x_q;
  logic [N-1:0]   y_q;
  logic           sub_q;
  logic [3:0]     grant_q;
  logic           busy_q;
  logic           done_q;
  logic [1:0]     id_q;
  logic [N-1:0]   s_q;
  logic           cout_q;
  logic           ovf_q;

  logic [1:0]     win_d;
  logic           found_d;
  logic [N-1:0]   x_d;
  logic [N-1:0]   y_d;
  logic [N-1:0]   ym_d;
  logic [N:0]     sum_d;
  logic           ovf_d;

  // Cyclic search for the first active request starting at ptr_q
  always_comb begin
    logic [1:0] idx;
    win_d   = ptr_q;
    found_d = 1'b0;
    idx     = ptr_q;
    for (int i = 0; i < 4; i++) begin
      idx = ptr_q + 2'(i);
      if (!found_d && Req[idx]) begin
        win_d   = idx;
        found_d = 1'b1;
      end
    end
  end

  always_comb begin
    x_d = '0;
    y_d = '0;
    for (int i = 0; i < 4; i++) begin
      if (win_d == 2'(i)) begin
        x_d = X_all[i*N +: N];
        y_d = Y_all[i*N +: N];
      end
    end
  end

  always_comb begin
    ym_d  = sub_q ? ~y_q : y_q;
    sum_d = {1'b0, x_q} + {1'b0, ym_d} + {{N{1'b0}}, sub_q};
    ovf_d = (x_q[N-1] == ym_d[N-1]) && (sum_d[N-1] != x_q[N-1]);
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      w_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      sub_q   <= 1'b0;
      grant_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      id_q    <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (found_d) begin
            w_q     <= win_d;
            x_q     <= x_d;
            y_q     <= y_d;
            sub_q   <= Sub[win_d];
            grant_q <= 4'b0001 << win_d;
            busy_q  <= 1'b1;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          s_q     <= sum_d[N-1:0];
          cout_q  <= sum_d[N];
          ovf_q   <= ovf_d;
          id_q    <= w_q;
          done_q  <= 1'b1;
          state_q <= RESP;
        end
        RESP: begin
          done_q  <= 1'b0;
          grant_q <= '0;
          busy_q  <= 1'b0;
          ptr_q   <= w_q + 2'd1;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          grant_q <= '0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign Grant    = grant_q;
  assign Busy     = busy_q;
  assign Done     = done_q;
  assign Id       = id_q;
  assign S        = s_q;
  assign Cout     = cout_q;
  assign Overflow = ovf_q;

endmodule

// File: doc/addsub_arbiter.md
Name: addsub_arbiter

Overview:
Round-robin arbiter and sequencer that shares one N-bit add/subtract datapath among four requesters.
Each requester presents its own operands and operation on a request line. The block grants one requester, latches that requester's operands, and computes the result in a registered execute cycle. It then returns sum, carry and signed overflow with a one-cycle Done strobe tagged with the winner's index.
It sits between the requesting control units and the adder/comparator resources and replaces four private adders with one.

Parameters:
N, 8, operand and result width in bits (N >= 2).

Ports:
Clock  input  1  system clock; all state changes on the rising edge.
Resetn  input  1  asynchronous, active-low reset.
Req  input  4  per-requester request; Req[i] is level, held by requester i until served.
X_all  input  4*N  operands X; requester i occupies bits [i*N+N-1 : i*N].
Y_all  input  4*N  operands Y, same packing as X_all.
Sub  input  4  per-requester op: 0 = X+Y, 1 = X-Y.
Grant  output  4  one-hot grant; all zero when no requester is granted.
Busy  output  1  high while an operation is in flight (EXEC or RESP).
Done  output  1  one-cycle strobe; result fields are valid.
Id  output  2  index of the requester whose result is on S/Cout/Overflow.
S  output  N  result.
Cout  output  1  carry out of bit N-1. For a subtract, 1 = no borrow.
Overflow  output  1  two's-complement overflow of the selected operation.

Behaviour:
- Reset (Resetn=0, asynchronous):
  - State=IDLE.
  - Grant=0, Busy=0, Done=0, Id=0, S=0, Cout=0, Overflow=0.
  - Round-robin pointer Ptr=0.
  - Latched operands are cleared.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant=0, Busy=0, Done=0.
  - If Req != 0 at an edge: the winner is the first set Req[i] searched cyclically from index Ptr (Ptr, Ptr+1, ... mod 4).
  - On that edge: latch X_i, Y_i, Sub[i] and winner index W; set Grant=onehot(W); go to EXEC.
  - If Req == 0: stay in IDLE.
- EXEC:
  - Grant=onehot(W), Busy=1.
  - On the edge, register the computation:
    - S = X + (Sub ? ~Y : Y) + Sub, truncated to N bits; Cout = bit N of that (N+1)-bit sum.
    - Overflow = (Xmsb == Y'msb) && (Smsb != Xmsb), where Y' = (Sub ? ~Y : Y).
  - Then go to RESP.
- RESP:
  - Done=1, Id=W, Grant=onehot(W), Busy=1.
  - On the edge: Ptr = (W+1) mod 4; go to IDLE.
- Latency: request sampled at edge k → Grant visible after edge k, Done high in the cycle after edge k+1. Throughput is one operation per 3 cycles.
- Result retention: S/Cout/Overflow/Id hold their last values after Done until the next RESP. Only Done qualifies them.
- Operand capture:
  - Operands are captured only at the IDLE→EXEC edge.
  - Changes to X_all/Y_all/Sub afterwards do not affect the in-flight operation.
- Withdrawal: if the winner drops Req during EXEC or RESP, the operation still completes and Done still fires.
- Re-request: a requester still asserting Req in the IDLE cycle after its RESP is treated as a new request. It wins only if no requester between Ptr and itself is asserting Req.
- Starvation: with Ptr advancing past each winner, every continuously asserted requester is granted within 4 operations (12 cycles).
- Requests arriving during EXEC/RESP are not lost: they are evaluated in the next IDLE.
- Reset mid-operation:
  - Outputs clear immediately (asynchronous) and no Done is issued for the aborted operation.
  - After release, arbitration restarts from Ptr=0.
- Grant is never multi-hot. Done is never high for two consecutive cycles.

Test Plan:
1. Resetn=0 with Req=4'hF → Grant=0, Busy=0, Done=0, S=0. After release, first grant is Grant=4'b0001.
2. N=8, Req=4'b0001, X0=8'h7F, Y0=8'h01, Sub0=0 → Grant=0001 for 2 cycles. In the second cycle: Done=1, Id=0, S=8'h80, Cout=0, Overflow=1.
3. Req=4'b0100, X2=8'h05, Y2=8'h07, Sub2=1 → Done with Id=2, S=8'hFE, Cout=0, Overflow=0. Also X2=8'h80, Y2=8'h01, Sub2=1 → S=8'h7F, Cout=1, Overflow=1.
4. Req=4'hF held continuously → Id sequence 0,1,2,3,0 with Done exactly every 3 cycles. Grant is one-hot throughout.
5. After requester 1 is served, Req=4'b1010 held → next Id=3, then Id=1 (Ptr=2 skips 1). Changing X3 during EXEC does not change S.
6. Resetn pulsed low during EXEC of requester 2 → Grant=0 immediately, no Done. With Req=4'b0101 after release, Grant=0001 first.
